fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Shares one synchronous FIFO write port among NUM_REQ producers using round-robin arbitration with bounded bursts. The block drives the FIFO's wr_en/data_in from registers, watches the FIFO's full, count and overflow status, and never issues a write that could overflow. It sits directly in front of the existing FIFO, between the producers and its write side.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, word width; equals the FIFO DATA_WIDTH
DEPTH, 32, FIFO depth in words
CNT_W, 6, width of the fifo_count input (must hold DEPTH)
BURST_LEN, 4, max words accepted per grant (1..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester "word available", level
req_data  in  NUM_REQ*DATA_WIDTH  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
ack  out  NUM_REQ  one-hot pulse: requester i word accepted this cycle (combinational)
grant  out  NUM_REQ  registered one-hot current owner; 0 when idle
busy  out  1  high in BURST state
fifo_wr_en  out  1  registered write strobe to the FIFO
fifo_data  out  DATA_WIDTH  registered write data to the FIFO
fifo_full  in  1  FIFO full flag
fifo_count  in  CNT_W  FIFO occupancy
fifo_overflow  in  1  FIFO overflow flag
err_overflow  out  1  sticky; set if fifo_overflow is ever seen high

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, grant=0, rr_ptr=0, burst_cnt=0, fifo_wr_en=0, fifo_data=0, err_overflow=0, busy=0. Reset mid-burst aborts the burst immediately. A word that is mid-flight in the output register is dropped.
- Two-state FSM: IDLE, BURST.
- IDLE: if any req is set, pick the winner g as the first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Register grant=onehot(g), clear burst_cnt, and go to BURST. No word is accepted in IDLE, so there is a 1-cycle arbitration bubble.
- Space guard: space_ok = !fifo_full && (fifo_count + fifo_wr_en) < DEPTH.
  - Compute the comparison CNT_W+1 bits wide.
  - This accounts for the registered write that has not yet reached the count.
  - Reads are ignored, so the guard is conservative.
- BURST accept: accept = req[g] && space_ok.
  - On accept: ack[g]=1 in the same cycle. The next cycle has fifo_wr_en=1 and fifo_data=req_data[g]. burst_cnt increments.
  - Otherwise fifo_wr_en=0 next cycle.
  - Latency from accept to the write strobe is exactly 1 cycle.
- BURST exit, to IDLE with rr_ptr=(g+1) mod NUM_REQ and grant cleared next cycle:
  - (a) accept while burst_cnt==BURST_LEN-1, or
  - (b) req[g]==0.
- Stall: in BURST with req[g]=1 and !space_ok, hold grant, no ack, no burst_cnt change. There is no timeout.
- Requesters must hold req_data stable until ack, and may drop req at any time. Changing req while not granted has no effect on the current burst.
- ack is always zero or one-hot, and only for the granted index.
- err_overflow sets on any cycle with fifo_overflow=1 and clears only on reset.
- Fairness: a continuously requesting port waits at most (NUM_REQ-1)*(BURST_LEN+1) cycles plus stall cycles.

Decomposition:
- Shared package fifo_arb_pkg: state encoding (IDLE, BURST) and the default-width localparams.
- One sub-module, rr_pick: combinational round-robin priority encoder. Inputs: req vector and rr_ptr. Outputs: winner index and any_req.
- The FSM, guard and output registers stay in fifo_wr_arbiter.

Test Plan:
- Reset with all req high and rst_n low: all outputs 0. After release, grant=0001 one cycle later, first ack[0] the cycle after, fifo_wr_en follows 1 cycle after ack.
- req=1111 held, FIFO draining freely: ack order is 4×r0, 4×r1, 4×r2, 4×r3, then r0. Exactly one idle cycle between bursts, 16 writes over 20 cycles.
- Single requester r2 with data 0x20..0x2B (12 words): three bursts of 4. FIFO contents are 0x20..0x2B in order, and grant returns to r2 after each IDLE cycle.
- Fill to fifo_count=31 with r1 requesting: exactly one more write, then ack stays 0 with grant held. After one FIFO read, acceptance resumes. fifo_full is never followed by fifo_wr_en=1, and err_overflow stays 0.
- r3 drops req after 2 words: BURST exits, rr_ptr=0, and the next grant goes to r0 when req=1001.
- Force fifo_overflow=1 for 1 cycle: err_overflow=1 and stays 1 until rst_n pulses low.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and default sizing.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } arb_state_e;

    localparam int unsigned NumReqDef    = 4;
    localparam int unsigned DataWidthDef = 8;
    localparam int unsigned DepthDef     = 32;
    localparam int unsigned CntWDef      = 6;
    localparam int unsigned BurstLenDef  = 4;

    // Wide enough for any burst length up to 15.
    localparam int unsigned BurstCntW    = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after rr_ptr_i.
module rr_pick #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   rr_ptr_i,
    output logic [IdxW-1:0]   winner_o,
    output logic              any_req_o
);

    logic            found;
    logic [IdxW-1:0] idx;

    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned off = 0; off < NumReq; off++) begin
            idx = IdxW'((32'(rr_ptr_i) + off) % NumReq);
            if (!found && req_i[idx]) begin
                found    = 1'b1;
                winner_o = idx;
            end
        end
        any_req_o = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among NumReq producers.
// Writes are issued from registers and only when the FIFO is guaranteed to have room.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NumReq    = NumReqDef,
    parameter int unsigned DataWidth = DataWidthDef,
    parameter int unsigned Depth     = DepthDef,
    parameter int unsigned CntW      = CntWDef,
    parameter int unsigned BurstLen  = BurstLenDef
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumReq-1:0]             req_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]             ack_o,
    output logic [NumReq-1:0]             grant_o,
    output logic                          busy_o,
    output logic                          fifo_wr_en_o,
    output logic [DataWidth-1:0]          fifo_data_o,
    input  logic                          fifo_full_i,
    input  logic [CntW-1:0]               fifo_count_i,
    input  logic                          fifo_overflow_i,
    output logic                          err_overflow_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    arb_state_e           state_q, state_d;
    logic [NumReq-1:0]    grant_q, grant_d;
    logic [IdxW-1:0]      gidx_q, gidx_d;
    logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BurstCntW-1:0] burst_cnt_q, burst_cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 err_q, err_d;

    logic [DataWidth-1:0] req_words [NumReq];
    logic [IdxW-1:0]      winner;
    logic                 any_req;
    logic [CntW:0]        occupancy;
    logic                 space_ok;
    logic                 req_g;
    logic                 accept;
    logic                 last_word;

    for (genvar i = 0; i < NumReq; i++) begin : g_unpack
        assign req_words[i] = req_data_i[i*DataWidth +: DataWidth];
    end

    rr_pick #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_rr_pick (
        .req_i     (req_i),
        .rr_ptr_i  (rr_ptr_q),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    // The write still sitting in the output register is not yet reflected in fifo_count_i.
    assign occupancy = {1'b0, fifo_count_i} + {{CntW{1'b0}}, wr_en_q};
    assign space_ok  = !fifo_full_i && (occupancy < (CntW+1)'(Depth));
    assign req_g     = req_i[gidx_q];
    assign accept    = (state_q == StBurst) && req_g && space_ok;
    assign last_word = (burst_cnt_q == BurstCntW'(BurstLen - 1));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        wr_en_d     = 1'b0;
        data_d      = data_q;
        err_d       = err_q | fifo_overflow_i;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d         = StBurst;
                    grant_d         = '0;
                    grant_d[winner] = 1'b1;
                    gidx_d          = winner;
                    burst_cnt_d     = '0;
                end
            end
            StBurst: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    data_d      = req_words[gidx_q];
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
                if ((accept && last_word) || !req_g) begin
                    state_d  = StIdle;
                    grant_d  = '0;
                    rr_ptr_d = (gidx_q == IdxW'(NumReq - 1)) ? '0 : gidx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign ack_o          = accept ? grant_q : '0;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q == StBurst);
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_o    = data_q;
    assign err_overflow_o = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: expected write words are queued per scenario and a
// negedge monitor pops and compares them against every FIFO write strobe.
module tb_fifo_wr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned D  = 32;
    localparam int unsigned CW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic            fifo_full;
    logic [CW-1:0]   fifo_count;
    logic            fifo_overflow;
    logic            err_overflow;

    logic drain = 1'b0, rd_pulse = 1'b0, preload = 1'b0, force_ovf = 1'b0;
    logic rd;
    logic full_prev = 1'b0;

    int checks = 0;
    int errors = 0;
    int left [N];
    int cnt  [N];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NumReq    (N),
        .DataWidth (DW),
        .Depth     (D),
        .CntW      (CW),
        .BurstLen  (4)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req),
        .req_data_i      (req_data),
        .ack_o           (ack),
        .grant_o         (grant),
        .busy_o          (busy),
        .fifo_wr_en_o    (fifo_wr_en),
        .fifo_data_o     (fifo_data),
        .fifo_full_i     (fifo_full),
        .fifo_count_i    (fifo_count),
        .fifo_overflow_i (fifo_overflow),
        .err_overflow_o  (err_overflow)
    );

    // Occupancy model of the downstream FIFO.
    assign rd            = rd_pulse || (drain && fifo_count != '0);
    assign fifo_full     = (fifo_count == CW'(D));
    assign fifo_overflow = force_ovf || (fifo_wr_en && fifo_full && !rd);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       fifo_count <= '0;
        else if (preload) fifo_count <= CW'(D - 1);
        else              fifo_count <= fifo_count + CW'(fifo_wr_en) - CW'(rd);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        logic [DW-1:0] w;
        if (rst_n) begin
            if (fifo_wr_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_data: got %02h, expected no write", fifo_data);
                end else begin
                    w = exp_q.pop_front();
                    if (w != fifo_data) begin
                        errors++;
                        $display("FAIL wr_data: got %02h expected %02h", fifo_data, w);
                    end
                end
                checks++;
                if (full_prev) begin
                    errors++;
                    $display("FAIL wr_after_full: got wr_en=1 expected 0");
                end
            end
            if (ack != '0) begin
                checks++;
                if (!$onehot(ack) || (ack & ~grant) != '0) begin
                    errors++;
                    $display("FAIL ack_onehot: got ack=%b grant=%b expected one-hot within grant",
                             ack, grant);
                end
            end
        end
        full_prev = fifo_full;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            req[i]             = (left[i] > 0);
            req_data[i*DW +: DW] = DW'(i * 16 + cnt[i]);
        end
    endtask

    // One clock: sample ack before the edge, account the accepted word after it.
    task automatic tick(output logic [N-1:0] a);
        @(negedge clk);
        a = ack;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                left[i]--;
                cnt[i]++;
            end
        end
        #1;
        drive_req();
    endtask

    task automatic wait_idle();
        logic [N-1:0] a;
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (left[0] == 0 && left[1] == 0 && left[2] == 0 && left[3] == 0 &&
                !busy && !fifo_wr_en)
                done = 1;
            else
                tick(a);
        end
        chk("idle_timeout", int'(done), 1);
    endtask

    task automatic clear_cnt();
        for (int i = 0; i < N; i++) cnt[i] = 0;
    endtask

    function automatic logic [N-1:0] exp_rr(input int k);
        if (k == 21) return 4'b0001;
        if (k >= 20 || k % 5 == 0) return '0;
        return 4'(1 << (k / 5));
    endfunction

    initial begin
        logic [N-1:0] a;
        int acks;

        // Reset with every requester asserting.
        left = '{5, 4, 4, 4};
        clear_cnt();
        drive_req();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", int'(ack), 0);
        chk("rst_grant", int'(grant), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_wr_en", int'(fifo_wr_en), 0);
        chk("rst_data", int'(fifo_data), 0);
        chk("rst_err", int'(err_overflow), 0);

        // Full round robin with the FIFO draining freely.
        for (int r = 0; r < N; r++)
            for (int j = 0; j < 4; j++) exp_q.push_back(DW'(r * 16 + j));
        exp_q.push_back(8'h04);
        drain = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick(a);
            chk($sformatf("rr_ack_k%0d", k), int'(a), int'(exp_rr(k)));
            if (k == 0) chk("first_grant", int'(grant), 1);
            if (k == 1) chk("first_wr_en", int'(fifo_wr_en), 1);
        end
        wait_idle();

        // Single requester: three back-to-back bursts of four.
        clear_cnt();
        left[2] = 12;
        for (int j = 0; j < 12; j++) exp_q.push_back(DW'(8'h20 + j));
        drive_req();
        for (int k = 0; k < 16; k++) begin
            tick(a);
            chk($sformatf("r2_ack_k%0d", k), int'(a), (k < 15 && k % 5 != 0) ? 4 : 0);
            if (k % 5 == 0 && k < 15) chk($sformatf("r2_grant_k%0d", k), int'(grant), 4);
        end
        wait_idle();

        // Nearly full FIFO: one more write, then stall until a read frees a slot.
        drain   = 1'b0;
        preload = 1'b1;
        @(posedge clk);
        #1;
        preload = 1'b0;
        chk("preload_count", int'(fifo_count), 31);
        clear_cnt();
        left[1] = 3;
        exp_q.push_back(8'h10);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        drive_req();
        acks = 0;
        for (int k = 0; k < 9; k++) begin
            tick(a);
            if (a != '0) acks++;
        end
        chk("stall_acks", acks, 1);
        chk("stall_grant", int'(grant), 2);
        chk("stall_busy", int'(busy), 1);
        rd_pulse = 1'b1;
        tick(a);
        rd_pulse = 1'b0;
        acks = (a != '0) ? 1 : 0;
        for (int k = 0; k < 4; k++) begin
            tick(a);
            if (a != '0) acks++;
        end
        chk("resume_acks", acks, 1);
        drain = 1'b1;
        wait_idle();
        chk("no_overflow_err", int'(err_overflow), 0);

        // Owner drops request mid-burst; pointer moves past it.
        clear_cnt();
        left[3] = 2;
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h31);
        drive_req();
        wait_idle();
        cnt[0]  = 0;
        left[0] = 1;
        left[3] = 1;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h32);
        drive_req();
        tick(a);
        chk("grant_after_drop", int'(grant), 1);
        wait_idle();

        // Sticky overflow flag.
        force_ovf = 1'b1;
        tick(a);
        force_ovf = 1'b0;
        chk("ovf_set", int'(err_overflow), 1);
        repeat (5) tick(a);
        chk("ovf_sticky", int'(err_overflow), 1);
        rst_n = 1'b0;
        #1;
        chk("ovf_cleared", int'(err_overflow), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) tick(a);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
